dmem_requester: RTL and testbench
=================================

# dmem_requester

Initiator for the banked 8K-word data memory. Accepts byte, halfword and word load/store requests from the CPU datapath and drives `mem_addr`, `rw` and `data_in`, holding each access stable for the memory's fixed latency. It captures `dmem` and returns aligned, optionally sign-extended read data. Sub-word stores are performed as read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- `ADDR_W`, 13: word-address width toward the memory.
- `DATA_W`, 32: data width.
- `RD_LAT`, 3: cycles `mem_addr` and `rw=0` are held before `dmem` is sampled; must be ≥1.
- `WR_LAT`, 2: cycles `mem_addr`, `data_in` and `rw=1` are held for a write; must be ≥1.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed` in 1: sign-extend a sub-word load.
- `req_addr` in ADDR_W+2: byte address. Bits [ADDR_W+1:2] select the word; bits [1:0] select the lane.
- `req_wdata` in DATA_W: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out DATA_W: load result; 0 for stores and errors.
- `resp_err` out 1: the request was misaligned or illegal; valid with `resp_valid`.
- `mem_addr` out ADDR_W: word address to the memory.
- `rw` out 1: 1 = write, 0 = read.
- `data_in` out DATA_W: write data to the memory.
- `dmem` in DATA_W: read data from the memory.

## Operation
- FSM states:
  - IDLE: `req_ready=1`. On `req_valid` the block latches the request and selects the next state:
    - error → RESP
    - load → RD
    - word store → WR
    - sub-word store → RD with the RMW flag set
  - RD: `rw=0`, `mem_addr` = word address. The latency counter counts RD_LAT cycles, then `dmem` is captured.
    - Load → RESP.
    - RMW → WR, with `data_in` = captured word with the target lane(s) replaced.
  - WR: `rw=1`. Held for WR_LAT cycles → RESP.
  - RESP: `resp_valid=1`, `req_ready=0` → IDLE.
- Error conditions:
  - `req_size=3`.
  - Halfword with `req_addr[0]=1`.
  - Word with `req_addr[1:0]≠0`.
  - An error generates no memory access.
- Lanes are little-endian: lane 0 = bits [7:0], and halfword offset 2 = bits [31:16].
- Loads:
  - The selected lane is shifted to bit 0.
  - The upper bits are zero-filled, or filled with the lane MSB when `req_signed=1`.
- Stores: only `req_wdata[7:0]` (byte) or `[15:0]` (half) is used.
- Outside WR, `rw=0`. `mem_addr` and `data_in` hold their last values.
- Requests are not pipelined; one transaction is in flight at most.

## Timing
- Reset (async, `reset=0`):
  - State goes to IDLE.
  - These outputs go to 0: `req_ready`, `resp_valid`, `resp_err`, `resp_rdata`, `mem_addr`, `rw`, `data_in`.
  - `req_ready` rises in the first cycle after release.
- Reset mid-operation:
  - `rw` drops immediately and no response is produced.
  - A partially held write is undefined in memory, and software must reissue it.
- Let edge 0 be the edge that accepts the request. `resp_valid` is high for the single cycle following:
  - edge 0 for an error
  - edge RD_LAT for a load
  - edge WR_LAT for a word store
  - edge RD_LAT+WR_LAT for a sub-word store
- `resp_rdata` and `resp_err` are valid only while `resp_valid` is high. They are registered and hold until the next response.
- `req_ready` is low from edge 0 until the cycle after `resp_valid`. Peak throughput is one load per RD_LAT+2 cycles.
- `req_*` inputs are sampled only at the accept edge and may change afterwards.
- In RMW, the write begins the cycle immediately after the read capture. There is no idle cycle between `rw=0` and `rw=1`.

## Structure
- Shared package `dmem_pkg`:
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum (IDLE, RD, WR, RESP).
  - Default RD_LAT and WR_LAT.
- Sub-module `dmem_lane` (combinational):
  - Load extract and extend: word, offset, size, signed.
  - Store merge: old word, new data, offset, size.
- The FSM, latency counter and output registers stay in `dmem_requester`.

## Test plan
- Word round trip:
  - Store 0xDEADBEEF at byte 0x0010. Expect `resp_valid` after WR_LAT with `rw=1` held at `mem_addr=4`.
  - Load 0x0010. Expect 0xDEADBEEF after RD_LAT, `resp_err=0`.
- Sub-word loads from word 0x80FF7F01:
  - Byte offset 3 signed → 0xFFFFFF80.
  - Byte offset 0 unsigned → 0x00000001.
  - Half offset 2 signed → 0xFFFF80FF.
- Byte RMW:
  - Word holds 0x11223344. Store byte 0xAA at offset 1.
  - Expect `rw=0` for RD_LAT cycles, then `rw=1` with `data_in=0x1122AA44`, and `resp_valid` after RD_LAT+WR_LAT.
- Misaligned requests:
  - Word at 0x0002 and half at 0x0001 each give `resp_err=1` one cycle after accept.
  - `rw` never goes high and `mem_addr` is unchanged.
- Bank boundary: word store and load at word addresses 0x03FF and 0x0400 (banks 0 and 1) and 0x1FFF (last word). Each reads back its own value.
- Reset mid-write: deassert `reset` during WR. Expect `rw=0` asynchronously, no `resp_valid`, and `req_ready=1` the cycle after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data-memory requester.
// Request sizes, FSM states and default access latencies.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int DEF_RD_LAT = 3;
    localparam int DEF_WR_LAT = 2;

    // Illegal size, or a lane offset that does not fit the access size.
    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] offset);
        logic err;
        case (size_e'(size))
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = offset[0];
            SZ_WORD: err = (offset != 2'd0);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_requester_if.sv
// CPU-side request/response bundle of the data-memory requester.
// The master is the datapath; the slave is dmem_requester.
interface dmem_requester_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
// Purely combinational; offsets are assumed already checked for alignment.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] new_data,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;

    always_comb begin
        sh        = SH_W'({offset, 3'b000});
        shifted   = word >> sh;
        mask      = '0;
        load_data = word;
        merged    = new_data;
        case (size_e'(size))
            SZ_BYTE: begin
                load_data = {{(DATA_W-8){sgn & shifted[7]}}, shifted[7:0]};
                mask      = DATA_W'(8'hFF) << sh;
                merged    = (word & ~mask) | ((DATA_W'(new_data[7:0]) << sh) & mask);
            end
            SZ_HALF: begin
                load_data = {{(DATA_W-16){sgn & shifted[15]}}, shifted[15:0]};
                mask      = DATA_W'(16'hFFFF) << sh;
                merged    = (word & ~mask) | ((DATA_W'(new_data[15:0]) << sh) & mask);
            end
            default: begin
                load_data = word;
                merged    = new_data;
            end
        endcase
    end
endmodule

// File: rtl/dmem_requester.sv
// Initiator for the banked data memory: byte/half/word loads and stores,
// with sub-word stores done as read-modify-write of the whole word.
//
// state | meaning
// IDLE  | ready for a request (req_ready rises one cycle after reset)
// RD    | rw=0, address held for RD_LAT cycles, then dmem captured
// WR    | rw=1, address and data held for WR_LAT cycles
// RESP  | one-cycle resp_valid pulse, then back to IDLE
module dmem_requester
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic              clk,
    input  logic              reset,
    dmem_requester_if.slave   bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rw,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] dmem
);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              rmw;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;
    logic              acc_err;

    assign acc_err = req_is_err(bus.req_size, bus.req_addr[1:0]);

    dmem_lane #(.DATA_W(DATA_W)) u_lane (
        .word      (dmem),
        .offset    (r_off),
        .size      (r_size),
        .sgn       (r_signed),
        .new_data  (r_wdata),
        .load_data (ld_data),
        .merged    (st_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rmw            <= 1'b0;
            r_off          <= '0;
            r_size         <= '0;
            r_signed       <= 1'b0;
            r_wdata        <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            mem_addr       <= '0;
            rw             <= 1'b0;
            data_in        <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.req_ready) begin
                        bus.req_ready <= 1'b1;
                    end else if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        r_off         <= bus.req_addr[1:0];
                        r_size        <= bus.req_size;
                        r_signed      <= bus.req_signed;
                        r_wdata       <= bus.req_wdata;
                        if (acc_err) begin
                            // No memory access: mem_addr keeps its old value.
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            mem_addr <= bus.req_addr[ADDR_W+1:2];
                            if (bus.req_we && (size_e'(bus.req_size) == SZ_WORD)) begin
                                state   <= WR;
                                rmw     <= 1'b0;
                                rw      <= 1'b1;
                                data_in <= bus.req_wdata;
                                cnt     <= CNT_W'(WR_LAT - 1);
                            end else begin
                                state <= RD;
                                rmw   <= bus.req_we;
                                cnt   <= CNT_W'(RD_LAT - 1);
                            end
                        end
                    end
                end
                RD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rmw) begin
                        // Write starts right after the capture, no idle cycle.
                        state   <= WR;
                        rw      <= 1'b1;
                        data_in <= st_word;
                        cnt     <= CNT_W'(WR_LAT - 1);
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= ld_data;
                    end
                end
                WR: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state          <= RESP;
                        rw             <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_requester.sv
// Self-checking bench for dmem_requester: directed cases plus random traffic
// against a word-array memory and a byte-lane reference model.
module tb_dmem_requester;
    import dmem_pkg::*;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              rw;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] dmem;

    int errors = 0;
    int checks = 0;

    dmem_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_requester #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_addr (mem_addr),
        .rw       (rw),
        .data_in  (data_in),
        .dmem     (dmem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fill(input logic [12:0] a);
        return ({19'd0, a} * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    // Memory: unwritten words read a fixed address hash.
    logic [31:0] mem [8192];
    bit          vld [8192];
    always @(posedge clk) begin
        if (rw) begin
            mem[mem_addr] <= data_in;
            vld[mem_addr] <= 1'b1;
        end
    end
    assign dmem = vld[mem_addr] ? mem[mem_addr] : fill(mem_addr);

    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_rd(input int wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : fill(13'(wa));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xact(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [14:0] addr, input logic [31:0] wd, input string tag);
        int          off, wa, nbytes, lat, n, g, rw_cnt, rw_start;
        bit          err, got;
        logic [31:0] old, v, mask, exp_rd, exp_wr, wr_data;
        logic [12:0] prev_addr, wr_adr;

        off    = int'(addr[1:0]);
        wa     = int'(addr[14:2]);
        err    = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        old    = ref_rd(wa);
        exp_rd = '0;
        exp_wr = '0;
        lat    = 0;
        if (!err) begin
            if (!we) begin
                lat = RD_LAT;
                v   = old >> (8 * off);
                if (nbytes < 4) begin
                    mask = (32'd1 << (8 * nbytes)) - 32'd1;
                    v    = v & mask;
                    if (sg && v[8*nbytes-1]) v = v | ~mask;
                end
                exp_rd = v;
            end else begin
                exp_wr = old;
                for (int b = 0; b < nbytes; b++) exp_wr[8*(off+b) +: 8] = wd[8*b +: 8];
                lat         = (nbytes == 4) ? WR_LAT : RD_LAT + WR_LAT;
                ref_mem[wa] = exp_wr;
            end
        end

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        g = 0;
        while (!bus.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_ready"}, 32'(g < 50), 32'd1);
        prev_addr = mem_addr;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 15'($urandom);
        bus.req_wdata  = $urandom;

        got      = 1'b0;
        rw_cnt   = 0;
        rw_start = -1;
        wr_data  = '0;
        wr_adr   = '0;
        for (n = 0; n < 64; n++) begin
            if (rw) begin
                if (rw_start < 0) rw_start = n;
                rw_cnt++;
                wr_data = data_in;
                wr_adr  = mem_addr;
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, err});
        check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
        check({tag, "_rwcnt"}, 32'(rw_cnt), (we && !err) ? 32'(WR_LAT) : 32'd0);
        check({tag, "_busy"}, {31'd0, bus.req_ready}, 32'd0);
        if (we && !err) begin
            check({tag, "_rwstart"}, 32'(rw_start), (nbytes == 4) ? 32'd0 : 32'(RD_LAT));
            check({tag, "_wdata"}, wr_data, exp_wr);
            check({tag, "_waddr"}, {19'd0, wr_adr}, 32'(wa));
        end else if (err) begin
            check({tag, "_addr_kept"}, {19'd0, mem_addr}, {19'd0, prev_addr});
        end else begin
            check({tag, "_raddr"}, {19'd0, mem_addr}, 32'(wa));
        end
        @(posedge clk);
        #1;
        check({tag, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_err",   {31'd0, bus.resp_err}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_maddr", {19'd0, mem_addr}, 32'd0);
        check("rst_rw",    {31'd0, rw}, 32'd0);
        check("rst_din",   data_in, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_rise", {31'd0, bus.req_ready}, 32'd1);

        xact(1'b1, 2'd2, 1'b0, 15'h0010, 32'hDEADBEEF, "w_store");
        xact(1'b0, 2'd2, 1'b0, 15'h0010, 32'h0, "w_load");

        xact(1'b1, 2'd2, 1'b0, 15'h0020, 32'h80FF7F01, "sub_init");
        xact(1'b0, 2'd0, 1'b1, 15'h0023, 32'h0, "lb_off3_s");
        xact(1'b0, 2'd0, 1'b0, 15'h0020, 32'h0, "lbu_off0");
        xact(1'b0, 2'd1, 1'b1, 15'h0022, 32'h0, "lh_off2_s");
        xact(1'b0, 2'd1, 1'b0, 15'h0022, 32'h0, "lhu_off2");

        xact(1'b1, 2'd2, 1'b0, 15'h0030, 32'h11223344, "rmw_init");
        xact(1'b1, 2'd0, 1'b0, 15'h0031, 32'h556677AA, "rmw_byte");
        xact(1'b0, 2'd2, 1'b0, 15'h0030, 32'h0, "rmw_check");
        check("rmw_ref", ref_rd(32'h0C), 32'h1122AA44);
        xact(1'b1, 2'd1, 1'b0, 15'h0032, 32'hFFFF1357, "rmw_half");
        xact(1'b0, 2'd2, 1'b0, 15'h0030, 32'h0, "rmw_half_check");

        xact(1'b0, 2'd2, 1'b0, 15'h0002, 32'h0, "mis_word");
        xact(1'b1, 2'd1, 1'b0, 15'h0001, 32'h12345678, "mis_half");
        xact(1'b0, 2'd3, 1'b0, 15'h0004, 32'h0, "ill_size");

        xact(1'b1, 2'd2, 1'b0, 15'h0FFC, 32'hA5A5_03FF, "bank0_st");
        xact(1'b1, 2'd2, 1'b0, 15'h1000, 32'h5A5A_0400, "bank1_st");
        xact(1'b1, 2'd2, 1'b0, 15'h7FFC, 32'h0BAD_1FFF, "last_st");
        xact(1'b0, 2'd2, 1'b0, 15'h0FFC, 32'h0, "bank0_ld");
        xact(1'b0, 2'd2, 1'b0, 15'h1000, 32'h0, "bank1_ld");
        xact(1'b0, 2'd2, 1'b0, 15'h7FFC, 32'h0, "last_ld");

        for (int i = 0; i < 40; i++) begin
            xact(1'($urandom), 2'($urandom), 1'($urandom),
                 {5'h00, 8'($urandom_range(0, 31)), 2'($urandom)}, $urandom, "rnd");
        end

        // Reset during the write hold of a word store.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 15'h0400;
        bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("mid_rw_before", {31'd0, rw}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rw_async", {31'd0, rw}, 32'd0);
        check("mid_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) check("mid_ready_rise", {31'd0, bus.req_ready}, 32'd1);
            check("mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end

        xact(1'b0, 2'd2, 1'b0, 15'h0010, 32'h0, "post_rst_load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
